// File: rtl/matriz_varredura.sv
// LED-matrix driver: debounced switch capture, row frame buffer, time-multiplexed row scan.
// Latency: outputs registered; write/mode/debounce results forwarded into the same-edge output update.
// Backpressure: none; free-running scan, inputs accepted every cycle.
module matriz_varredura #(
  parameter int  N_COLS     = 5,
  parameter int  N_ROWS     = 7,
  parameter int  SCAN_DIV   = 4,
  parameter int  DEB_CYCLES = 3,
  localparam int ROW_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COLS-1:0] CH,
  input  logic              MODE,
  input  logic              WR,
  input  logic [ROW_W-1:0]  WR_ROW,
  input  logic              CLR,
  output logic [N_COLS-1:0] COL,
  output logic [N_ROWS-1:0] ROW_N
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_COLS-1:0] ch_m;
  logic [N_COLS-1:0] ch_s;

  logic [CNT_W-1:0]  cnt    [N_COLS];
  logic [CNT_W-1:0]  cnt_nx [N_COLS];
  logic [N_COLS-1:0] deb;
  logic [N_COLS-1:0] deb_nx;

  logic [N_COLS-1:0] pat;
  logic [N_COLS-1:0] pat_nx;

  logic [N_COLS-1:0] frame    [N_ROWS];
  logic [N_COLS-1:0] frame_nx [N_ROWS];

  logic [PRE_W-1:0]  pre;
  logic [PRE_W-1:0]  pre_nx;
  logic [ROW_W-1:0]  r;
  logic [ROW_W-1:0]  r_nx;

  logic [N_COLS-1:0] col_nx;
  logic [N_ROWS-1:0] row_n_nx;

  // Two-flop synchroniser for the raw asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_m <= '0;
      ch_s <= '0;
    end else begin
      ch_m <= CH;
      ch_s <= ch_m;
    end
  end

  // Per-channel debounce: count consecutive mismatches, flip the stable bit on the last one.
  always_comb begin
    for (int i = 0; i < N_COLS; i++) begin
      deb_nx[i] = deb[i];
      cnt_nx[i] = '0;
      if (ch_s[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nx[i] = ch_s[i];
        end else begin
          cnt_nx[i] = CNT_W'(cnt[i] + 1'b1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < N_COLS; i++) cnt[i] <= '0;
    end else begin
      deb <= deb_nx;
      for (int i = 0; i < N_COLS; i++) cnt[i] <= cnt_nx[i];
    end
  end

  // Column 0 is driven by the highest-numbered switch; the next-state copy feeds DIRECT output.
  always_comb begin
    for (int i = 0; i < N_COLS; i++) begin
      pat[i]    = deb[N_COLS-1-i];
      pat_nx[i] = deb_nx[N_COLS-1-i];
    end
  end

  // Frame-buffer next state: clear wins over write; out-of-range rows match no entry.
  always_comb begin
    for (int k = 0; k < N_ROWS; k++) begin
      frame_nx[k] = frame[k];
      if (CLR) begin
        frame_nx[k] = '0;
      end else if (WR && (int'(WR_ROW) == k)) begin
        frame_nx[k] = pat;
      end
    end
  end

  // Frame-buffer storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_ROWS; k++) frame[k] <= '0;
    end else begin
      for (int k = 0; k < N_ROWS; k++) frame[k] <= frame_nx[k];
    end
  end

  // Scan position next state: prescaler wraps and steps the row index at its last count.
  always_comb begin
    pre_nx = pre + 1'b1;
    r_nx   = r;
    if (pre == PRE_LAST) begin
      pre_nx = '0;
      r_nx   = (r == ROW_LAST) ? '0 : ROW_W'(r + 1'b1);
    end
  end

  // Scan position registers; they keep running in either mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      r   <= '0;
    end else begin
      pre <= pre_nx;
      r   <= r_nx;
    end
  end

  // Output next state built from the post-edge scan position so the visible cycle matches pre.
  // The frame and pattern are forwarded so a same-row write shows on the very next cycle.
  always_comb begin
    col_nx   = '0;
    row_n_nx = '1;
    if (!MODE) begin
      col_nx   = pat_nx;
      row_n_nx = '0;
    end else if (pre_nx != '0) begin
      col_nx   = frame_nx[r_nx];
      row_n_nx = ~(N_ROWS'(1) << r_nx);
    end
  end

  // Registered matrix drive; reset state is the blank pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      COL   <= '0;
      ROW_N <= '1;
    end else begin
      COL   <= col_nx;
      ROW_N <= row_n_nx;
    end
  end

endmodule

// File: tb/tb_matriz_varredura.sv
// Bench for matriz_varredura with default parameters.
// Stimulus pushes the expected per-cycle drive into a queue; a negedge monitor pops and compares.
module tb_matriz_varredura;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] CH;
  logic       MODE;
  logic       WR;
  logic [2:0] WR_ROW;
  logic       CLR;
  logic [4:0] COL;
  logic [6:0] ROW_N;

  always #5 clk = ~clk;

  matriz_varredura dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .CH     (CH),
    .MODE   (MODE),
    .WR     (WR),
    .WR_ROW (WR_ROW),
    .CLR    (CLR),
    .COL    (COL),
    .ROW_N  (ROW_N)
  );

  typedef struct {
    logic [4:0] col;
    logic [6:0] rown;
    int         t;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         t      = 0;
  int         live_row = 0;
  bit         exp_rst;
  bit         exp_mode;
  logic [4:0] exp_pat;
  logic [4:0] exp_frame [7];
  string      phase = "init";

  // Advance one cycle and queue the hand-derived drive expected in the cycle just begun.
  task automatic nxt();
    exp_t e;
    @(posedge clk);
    #1;
    t++;
    e.t   = t;
    e.tag = phase;
    if (exp_rst) begin
      e.col  = 5'b00000;
      e.rown = 7'b1111111;
    end else if (!exp_mode) begin
      e.col  = exp_pat;
      e.rown = 7'b0000000;
    end else if ((t % 4) == 0) begin
      e.col  = 5'b00000;
      e.rown = 7'b1111111;
    end else begin
      e.col  = exp_frame[(t / 4) % 7];
      e.rown = ~(7'b0000001 << ((t / 4) % 7));
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) nxt();
  endtask

  // Step until the scan sits at the requested prescaler phase (and row, if row >= 0).
  task automatic wait_pos(input int p, input int row);
    for (int k = 0; k < 28; k++) begin
      if ((t % 4) == p && (row < 0 || ((t / 4) % 7) == row)) break;
      nxt();
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 7; i++) exp_frame[i] = 5'b00000;
  endtask

  // Monitor: compares the DUT drive against the queued expectation every cycle one is present.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (COL !== e.col || ROW_N !== e.rown) begin
          n_fail++;
          $display("FAIL %s t=%0d: got COL=%b ROW_N=%b, want COL=%b ROW_N=%b",
                   e.tag, e.t, COL, ROW_N, e.col, e.rown);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    CH     = 5'b11111;
    MODE   = 1'b1;
    WR     = 1'b0;
    WR_ROW = 3'd0;
    CLR    = 1'b0;
    exp_rst  = 1'b1;
    exp_mode = 1'b1;
    exp_pat  = 5'b00000;
    clear_model();

    phase = "reset_hold";
    run(5);

    // The current cycle holds reset state: it is the blank cycle of row 0.
    rst_n   = 1'b1;
    CH      = 5'b00000;
    exp_rst = 1'b0;
    t       = 0;
    phase   = "scan_empty";
    run(32);

    phase    = "direct_deb";
    MODE     = 1'b0;
    exp_mode = 1'b0;
    CH       = 5'b00001;
    run(4);
    exp_pat = 5'b10000;
    run(4);

    phase = "glitch";
    CH    = 5'b00101;
    run(2);
    CH    = 5'b00001;
    run(8);

    phase = "deb_10110";
    CH    = 5'b10110;
    run(4);
    exp_pat = 5'b01101;
    run(3);

    phase  = "write_row2";
    WR     = 1'b1;
    WR_ROW = 3'd2;
    exp_frame[2] = 5'b01101;
    run(1);
    WR = 1'b0;

    phase    = "scan_row2";
    MODE     = 1'b1;
    exp_mode = 1'b1;
    run(60);

    phase  = "wr_row7";
    WR     = 1'b1;
    WR_ROW = 3'd7;
    run(1);
    WR = 1'b0;
    run(30);

    phase  = "wr_and_clr";
    WR     = 1'b1;
    WR_ROW = 3'd5;
    CLR    = 1'b1;
    clear_model();
    run(1);
    WR  = 1'b0;
    CLR = 1'b0;
    run(30);

    phase = "wr_live_row";
    wait_pos(1, -1);
    live_row = (t / 4) % 7;
    WR       = 1'b1;
    WR_ROW   = 3'(live_row);
    exp_frame[live_row] = 5'b01101;
    run(1);
    WR = 1'b0;
    run(30);

    phase = "mode_hop";
    wait_pos(1, live_row);
    MODE     = 1'b0;
    exp_mode = 1'b0;
    run(2);
    MODE     = 1'b1;
    exp_mode = 1'b1;
    run(30);

    phase = "rst_mid_row4";
    wait_pos(2, 4);
    rst_n   = 1'b0;
    exp_rst = 1'b1;
    run(1);
    rst_n   = 1'b1;
    exp_rst = 1'b0;
    t       = 0;
    clear_model();
    phase = "after_rst";
    run(40);

    phase    = "direct_end";
    MODE     = 1'b0;
    exp_mode = 1'b0;
    run(4);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
